// File: rtl/bus_watchdog.sv
// Bus-termination merger and unterminated-AS timeout watchdog for the 68030 bus.
// Optional macro BUSWD_STATS_EN builds the saturating timeoutCount register.
module bus_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 8
) (
    input  logic       sysClk,
    input  logic       reset,
    input  logic       nAS,
    input  logic       addr31,
    input  logic       RnW,
    input  logic [1:0] nDsackMem,
    input  logic       nStermMem,
    input  logic       nBerrMem,
    input  logic [1:0] nDsackIo,
    input  logic       nBerrIo,
    input  logic       clrFault,
    output logic [1:0] nDsack,
    output logic       nSterm,
    output logic       nBerr,
    output logic       faultFlag,
    output logic       faultIo,
    output logic       faultRead,
    output logic [7:0] timeoutCount
);

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StTerm,
        StTimeout
    } stateE;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);

    stateE            stateQ, stateD;
    logic [CNT_W-1:0] countQ, countD;
    logic             berrGenQ, berrGenD;
    logic             term;
    logic             expire;
    logic             faultFlagQ, faultIoQ, faultReadQ;

    assign term = (nDsackMem != 2'b11) | (nDsackIo != 2'b11) | ~nStermMem | ~nBerrMem | ~nBerrIo;

    // State register
    always_ff @(posedge sysClk or posedge reset) begin
        if (reset) begin
            stateQ   <= StIdle;
            countQ   <= '0;
            berrGenQ <= 1'b0;
        end else begin
            stateQ   <= stateD;
            countQ   <= countD;
            berrGenQ <= berrGenD;
        end
    end

    // Next-state logic; abort beats term, term beats expiry
    always_comb begin
        stateD = stateQ;
        countD = countQ;
        unique case (stateQ)
            StIdle: begin
                countD = '0;
                if (!nAS) begin
                    stateD = StActive;
                end
            end
            StActive: begin
                if (nAS) begin
                    stateD = StIdle;
                    countD = '0;
                end else if (term) begin
                    stateD = StTerm;
                end else if (countQ == CntLast) begin
                    stateD = StTimeout;
                end else begin
                    countD = countQ + 1'b1;
                end
            end
            StTerm: begin
                if (nAS) begin
                    stateD = StIdle;
                    countD = '0;
                end
            end
            StTimeout: begin
                if (nAS) begin
                    stateD = StIdle;
                    countD = '0;
                end
            end
            default: begin
                stateD = StIdle;
                countD = '0;
            end
        endcase
    end

    // Outputs: pure combinational merge plus the registered watchdog BERR
    always_comb begin
        berrGenD = (stateD == StTimeout);
        expire   = (stateQ == StActive) && !nAS && !term && (countQ == CntLast);
        nDsack   = nDsackMem & nDsackIo;
        nSterm   = nStermMem;
        nBerr    = nBerrMem & nBerrIo & ~berrGenQ;
    end

    // Sticky fault capture; a timeout on the same edge as clrFault wins
    always_ff @(posedge sysClk or posedge reset) begin
        if (reset) begin
            faultFlagQ <= 1'b0;
            faultIoQ   <= 1'b0;
            faultReadQ <= 1'b0;
        end else if (expire) begin
            faultFlagQ <= 1'b1;
            faultIoQ   <= addr31;
            faultReadQ <= RnW;
        end else if (clrFault) begin
            faultFlagQ <= 1'b0;
            faultIoQ   <= 1'b0;
            faultReadQ <= 1'b0;
        end
    end

    assign faultFlag = faultFlagQ;
    assign faultIo   = faultIoQ;
    assign faultRead = faultReadQ;

`ifdef BUSWD_STATS_EN
    logic [7:0] timeoutCountQ;

    always_ff @(posedge sysClk or posedge reset) begin
        if (reset) begin
            timeoutCountQ <= 8'h00;
        end else if (expire && (timeoutCountQ != 8'hff)) begin
            timeoutCountQ <= timeoutCountQ + 8'h01;
        end
    end

    assign timeoutCount = timeoutCountQ;
`else
    assign timeoutCount = 8'h00;
`endif

endmodule

// File: tb/tb_bus_watchdog.sv
// Randomized bench for bus_watchdog: a cycle-age reference model checked every clock,
// plus literal expectations from the directed bus scenarios.
module tb_bus_watchdog;

    localparam int unsigned TO = 64;
`ifdef BUSWD_STATS_EN
    localparam bit Stats = 1'b1;
`else
    localparam bit Stats = 1'b0;
`endif

    logic       sysClk = 1'b0;
    logic       reset = 1'b0;
    logic       nAS = 1'b1;
    logic       addr31 = 1'b0;
    logic       RnW = 1'b1;
    logic [1:0] nDsackMem = 2'b11;
    logic       nStermMem = 1'b1;
    logic       nBerrMem = 1'b1;
    logic [1:0] nDsackIo = 2'b11;
    logic       nBerrIo = 1'b1;
    logic       clrFault = 1'b0;
    logic [1:0] nDsack;
    logic       nSterm;
    logic       nBerr;
    logic       faultFlag;
    logic       faultIo;
    logic       faultRead;
    logic [7:0] timeoutCount;

    int tests = 0;
    int fails = 0;

    bus_watchdog #(
        .TIMEOUT_CYCLES(TO),
        .CNT_W(8)
    ) dut (
        .sysClk(sysClk),
        .reset(reset),
        .nAS(nAS),
        .addr31(addr31),
        .RnW(RnW),
        .nDsackMem(nDsackMem),
        .nStermMem(nStermMem),
        .nBerrMem(nBerrMem),
        .nDsackIo(nDsackIo),
        .nBerrIo(nBerrIo),
        .clrFault(clrFault),
        .nDsack(nDsack),
        .nSterm(nSterm),
        .nBerr(nBerr),
        .faultFlag(faultFlag),
        .faultIo(faultIo),
        .faultRead(faultRead),
        .timeoutCount(timeoutCount)
    );

    always #5 sysClk = ~sysClk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the edge index at which the current AS cycle began and
    // declares a timeout when an unterminated, unaborted cycle reaches age TO.
    wire         upTerm = (nDsackMem != 2'b11) || (nDsackIo != 2'b11) || !nStermMem ||
                          !nBerrMem || !nBerrIo;
    int unsigned edgeN = 0;
    int unsigned entryEdge = 0;
    bit          mWaiting = 0;   // AS low, nothing decided yet
    bit          mDone = 0;      // cycle decided (term or timeout), waiting for AS to rise
    bit          mBerrGen = 0;
    bit          mFlag = 0;
    bit          mIo = 0;
    bit          mRead = 0;
    int          mCnt = 0;

    always @(posedge sysClk or posedge reset) begin
        if (reset) begin
            edgeN <= 0;
            mWaiting <= 0;
            mDone <= 0;
            mBerrGen <= 0;
            mFlag <= 0;
            mIo <= 0;
            mRead <= 0;
            mCnt <= 0;
        end else begin
            edgeN <= edgeN + 1;
            if (clrFault) begin
                mFlag <= 0;
                mIo <= 0;
                mRead <= 0;
            end
            if (mDone) begin
                if (nAS) begin
                    mDone <= 0;
                    mBerrGen <= 0;
                end
            end else if (mWaiting) begin
                if (nAS) begin
                    mWaiting <= 0;
                end else if (upTerm) begin
                    mWaiting <= 0;
                    mDone <= 1;
                end else if (edgeN - entryEdge == TO) begin
                    mWaiting <= 0;
                    mDone <= 1;
                    mBerrGen <= 1;
                    mFlag <= 1;
                    mIo <= addr31;
                    mRead <= RnW;
                    mCnt <= (mCnt >= 255) ? 255 : mCnt + 1;
                end
            end else if (!nAS) begin
                mWaiting <= 1;
                entryEdge <= edgeN;
            end
        end
    end

    bit checking = 0;
    always @(negedge sysClk) begin
        if (checking) begin
            check("merge nDsack", 32'(nDsack), 32'(nDsackMem & nDsackIo));
            check("merge nSterm", 32'(nSterm), 32'(nStermMem));
            check("merge nBerr", 32'(nBerr), 32'(nBerrMem & nBerrIo & !mBerrGen));
            check("faultFlag", 32'(faultFlag), 32'(mFlag));
            check("faultIo", 32'(faultIo), 32'(mIo));
            check("faultRead", 32'(faultRead), 32'(mRead));
            check("timeoutCount", 32'(timeoutCount), Stats ? 32'(mCnt) : 32'd0);
        end
    end

    task automatic setTerm(input int kind, input bit on);
        case (kind)
            0: nDsackMem = on ? 2'b10 : 2'b11;
            1: nStermMem = !on;
            2: nBerrMem = !on;
            3: nDsackIo = on ? 2'b01 : 2'b11;
            4: nBerrIo = !on;
            default: ;
        endcase
    endtask

    // One AS cycle: term (if termDelay > 0) is sampled at the termDelay-th edge after entry.
    task automatic busCycle(input bit a31, input bit rnw, input int termDelay, input int kind,
                            input bit clrAtExpiry);
        int lowEdges;
        lowEdges = ((termDelay > int'(TO)) ? termDelay : int'(TO)) + 3;
        @(posedge sysClk);
        #1;
        addr31 = a31;
        RnW = rnw;
        nAS = 1'b0;
        for (int e = 1; e <= lowEdges; e++) begin
            @(posedge sysClk);
            #1;
            if (termDelay > 0 && e == termDelay) setTerm(kind, 1'b1);
            clrFault = clrAtExpiry && (e == int'(TO));
        end
        clrFault = 1'b0;
        nAS = 1'b1;
        for (int k = 0; k < 5; k++) setTerm(k, 1'b0);
        @(posedge sysClk);
        #1;
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (2) @(posedge sysClk);
        #1 reset = 1'b0;
        checking = 1;
        @(negedge sysClk);
        check("reset nBerr", 32'(nBerr), 32'd1);
        check("reset faultFlag", 32'(faultFlag), 32'd0);
        check("reset timeoutCount", 32'(timeoutCount), 32'd0);

        // ROM read terminated by memory DSACK after 4 clocks
        @(posedge sysClk);
        #1 nAS = 1'b0;
        repeat (4) @(posedge sysClk);
        #1 nDsackMem = 2'b10;
        #1;
        check("rom nDsack", 32'(nDsack), 32'h2);
        check("rom nBerr", 32'(nBerr), 32'd1);
        repeat (3) @(posedge sysClk);
        #1 nAS = 1'b1;
        nDsackMem = 2'b11;
        repeat (2) @(posedge sysClk);
        @(negedge sysClk);
        check("rom faultFlag", 32'(faultFlag), 32'd0);

        // STERM on the expiry edge wins over the timeout
        busCycle(1'b1, 1'b1, int'(TO), 1, 1'b0);
        @(negedge sysClk);
        check("sterm-expiry faultFlag", 32'(faultFlag), 32'd0);

        // Unanswered I/O read: BERR exactly TO clocks after entry
        @(posedge sysClk);
        #1 addr31 = 1'b1;
        RnW = 1'b1;
        nAS = 1'b0;
        @(posedge sysClk);
        repeat (TO - 1) @(posedge sysClk);
        @(negedge sysClk);
        check("io nBerr before expiry", 32'(nBerr), 32'd1);
        @(posedge sysClk);
        @(negedge sysClk);
        check("io nBerr at expiry", 32'(nBerr), 32'd0);
        check("io faultFlag", 32'(faultFlag), 32'd1);
        check("io faultIo", 32'(faultIo), 32'd1);
        check("io faultRead", 32'(faultRead), 32'd1);
        check("io timeoutCount", 32'(timeoutCount), Stats ? 32'd1 : 32'd0);
        @(posedge sysClk);
        #1 nAS = 1'b1;
        @(negedge sysClk);
        check("io nBerr held until edge", 32'(nBerr), 32'd0);
        @(negedge sysClk);
        check("io nBerr released", 32'(nBerr), 32'd1);

        // Asynchronous reset 10 clocks into an active cycle
        @(posedge sysClk);
        #1 nAS = 1'b0;
        repeat (10) @(posedge sysClk);
        #2 reset = 1'b1;
        #1;
        check("midreset nBerr", 32'(nBerr), 32'd1);
        check("midreset faultFlag", 32'(faultFlag), 32'd0);
        check("midreset timeoutCount", 32'(timeoutCount), 32'd0);
        #1 reset = 1'b0;
        @(posedge sysClk);
        #1 nAS = 1'b1;
        @(posedge sysClk);
        busCycle(1'b0, 1'b1, 0, 0, 1'b0);

        // Random cycles and clrFault pulses
        for (int n = 0; n < 60; n++) begin
            int d;
            d = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, TO + 4));
            busCycle(1'(($urandom)), 1'(($urandom)), d, int'($urandom_range(0, 4)),
                     ($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 3) == 0) begin
                #1 clrFault = 1'b1;
                @(posedge sysClk);
                #1 clrFault = 1'b0;
            end
        end

        // Timeout coinciding with clrFault after a prior fault
        @(posedge sysClk);
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        busCycle(1'b1, 1'b1, 0, 0, 1'b0);
        busCycle(1'b0, 1'b0, 0, 0, 1'b1);
        @(negedge sysClk);
        check("coincident faultFlag", 32'(faultFlag), 32'd1);
        check("coincident faultIo", 32'(faultIo), 32'd0);
        check("coincident faultRead", 32'(faultRead), 32'd0);
        @(posedge sysClk);
        #1 clrFault = 1'b1;
        @(posedge sysClk);
        #1 clrFault = 1'b0;
        @(negedge sysClk);
        check("lone clr faultFlag", 32'(faultFlag), 32'd0);
        check("lone clr timeoutCount", 32'(timeoutCount), Stats ? 32'd2 : 32'd0);

        // 256 consecutive timeouts from reset: counter saturates
        @(posedge sysClk);
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        for (int n = 0; n < 256; n++) begin
            busCycle(1'(($urandom)), 1'(($urandom)), 0, 0, 1'b0);
        end
        @(negedge sysClk);
        check("saturated timeoutCount", 32'(timeoutCount), Stats ? 32'd255 : 32'd0);

        checking = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
